// File: rtl/cache_lookup_ctrl.sv
// Tag directory and miss-handling controller for a set-associative cache.
// Looks up a request, refills from memory on a miss and advances the replacement counter.
module cache_lookup_ctrl #(
  parameter int unsigned AWIDTH = 6,
  parameter int unsigned WAYS   = 8,
  parameter int unsigned WWIDTH = 3,
  parameter int unsigned TWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_valid,
  output logic                     cpu_ready,
  input  logic [TWIDTH+AWIDTH-1:0] cpu_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [WWIDTH-1:0]        resp_way,
  output logic                     mem_req,
  output logic [TWIDTH+AWIDTH-1:0] mem_addr,
  input  logic                     mem_ack,
  output logic [AWIDTH-1:0]        rpl_addr,
  output logic                     rpl_wr,
  output logic                     rpl_hit,
  input  logic [WWIDTH-1:0]        rpl_way
);

  localparam int unsigned Sets = 2 ** AWIDTH;

  typedef enum logic [2:0] {StIdle, StLookup, StRefill, StUpdate, StResp} state_e;

  state_e state_q, state_d;

  logic [TWIDTH-1:0] tag_mem [WAYS][Sets];
  logic [Sets-1:0]   valid_q [WAYS];

  logic [TWIDTH-1:0] req_tag_q, req_tag_d;
  logic [AWIDTH-1:0] req_idx_q, req_idx_d;
  logic [WWIDTH-1:0] way_q, way_d;
  logic              hit_q, hit_d;
  logic              use_ctr_q, use_ctr_d;

  logic              hit_found, inv_found;
  logic [WWIDTH-1:0] hit_way, inv_way;

  // Scan downwards so the lowest-numbered match / invalid way wins.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx_q] && (tag_mem[w][req_idx_q] == req_tag_q)) begin
        hit_found = 1'b1;
        hit_way   = WWIDTH'(w);
      end
      if (!valid_q[w][req_idx_q]) begin
        inv_found = 1'b1;
        inv_way   = WWIDTH'(w);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    req_idx_d = req_idx_q;
    way_d     = way_q;
    hit_d     = hit_q;
    use_ctr_d = use_ctr_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_valid) begin
          req_tag_d = cpu_addr[TWIDTH+AWIDTH-1:AWIDTH];
          req_idx_d = cpu_addr[AWIDTH-1:0];
          state_d   = StLookup;
        end
      end
      StLookup: begin
        if (hit_found) begin
          way_d     = hit_way;
          hit_d     = 1'b1;
          use_ctr_d = 1'b0;
          state_d   = StResp;
        end else begin
          hit_d     = 1'b0;
          use_ctr_d = !inv_found;
          way_d     = inv_found ? inv_way : rpl_way;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        if (mem_ack) state_d = StUpdate;
      end
      StUpdate: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      req_tag_q <= '0;
      req_idx_q <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
      use_ctr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      req_idx_q <= req_idx_d;
      way_q     <= way_d;
      hit_q     <= hit_d;
      use_ctr_q <= use_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else if (state_q == StUpdate) begin
      valid_q[way_q][req_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == StUpdate)) tag_mem[way_q][req_idx_q] <= req_tag_q;
  end

  always_comb begin
    cpu_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_hit   = (state_q == StResp) && hit_q;
    resp_way   = (state_q == StResp) ? way_q : '0;
    mem_req    = (state_q == StRefill);
    mem_addr   = (state_q == StRefill) ? {req_tag_q, req_idx_q} : '0;
    rpl_wr     = (state_q == StUpdate) && use_ctr_q;
    rpl_hit    = 1'b0;
    rpl_addr   = (state_q == StIdle) ? cpu_addr[AWIDTH-1:0] : req_idx_q;
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Randomized self-checking bench for cache_lookup_ctrl against a set/way directory model
// and an external per-set round-robin counter.
module tb_cache_lookup_ctrl;

  localparam int unsigned AWIDTH = 6;
  localparam int unsigned WAYS   = 8;
  localparam int unsigned WWIDTH = 3;
  localparam int unsigned TWIDTH = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     cpu_valid;
  logic                     cpu_ready;
  logic [TWIDTH+AWIDTH-1:0] cpu_addr;
  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_hit;
  logic [WWIDTH-1:0]        resp_way;
  logic                     mem_req;
  logic [TWIDTH+AWIDTH-1:0] mem_addr;
  logic                     mem_ack;
  logic [AWIDTH-1:0]        rpl_addr;
  logic                     rpl_wr;
  logic                     rpl_hit;
  logic [WWIDTH-1:0]        rpl_way;

  int checks   = 0;
  int failures = 0;

  cache_lookup_ctrl #(
    .AWIDTH(AWIDTH),
    .WAYS  (WAYS),
    .WWIDTH(WWIDTH),
    .TWIDTH(TWIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_hit  (resp_hit),
    .resp_way  (resp_way),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .rpl_addr  (rpl_addr),
    .rpl_wr    (rpl_wr),
    .rpl_hit   (rpl_hit),
    .rpl_way   (rpl_way)
  );

  always #5 clk = ~clk;

  // External replacement counter: one round-robin pointer per set.
  logic [WWIDTH-1:0] ctr [64] = '{default: '0};
  int rpl_wr_cnt = 0;
  assign rpl_way = ctr[rpl_addr];
  always @(posedge clk) begin
    if (rpl_wr) begin
      ctr[rpl_addr] <= ctr[rpl_addr] + 1'b1;
      rpl_wr_cnt    <= rpl_wr_cnt + 1;
    end
  end

  // Reference directory.
  logic [7:0] m_tag   [64][8];
  bit         m_valid [64][8];
  int         m_ctr   [64];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic run_req(input logic [13:0] addr, input int ack_dly, input int rdy_dly,
                         input bit stray);
    int set;
    int tag;
    bit exp_hit;
    bit exp_ctr;
    bit found;
    int exp_way;
    int cnt0;
    set     = int'(addr[5:0]);
    tag     = int'(addr[13:6]);
    exp_hit = 1'b0;
    exp_ctr = 1'b0;
    exp_way = 0;
    for (int w = 0; w < 8; w++)
      if (!exp_hit && m_valid[set][w] && m_tag[set][w] == tag[7:0]) begin
        exp_hit = 1'b1;
        exp_way = w;
      end
    if (!exp_hit) begin
      found = 1'b0;
      for (int w = 0; w < 8; w++)
        if (!found && !m_valid[set][w]) begin
          found   = 1'b1;
          exp_way = w;
        end
      if (!found) begin
        exp_way    = m_ctr[set];
        exp_ctr    = 1'b1;
        m_ctr[set] = (m_ctr[set] + 1) % 8;
      end
      m_tag[set][exp_way]   = tag[7:0];
      m_valid[set][exp_way] = 1'b1;
    end
    cnt0 = rpl_wr_cnt;

    @(negedge clk);
    check_eq("idle_ready", cpu_ready, 1);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    #1 check_eq("idle_rpl_addr", rpl_addr, set);
    @(negedge clk);
    cpu_valid = 1'b0;
    check_eq("lookup_ready", cpu_ready, 0);
    check_eq("lookup_resp_valid", resp_valid, 0);
    check_eq("lookup_mem_req", mem_req, 0);
    check_eq("lookup_rpl_addr", rpl_addr, set);
    @(negedge clk);
    if (!exp_hit) begin
      check_eq("refill_mem_req", mem_req, 1);
      check_eq("refill_mem_addr", mem_addr, addr);
      check_eq("refill_resp_valid", resp_valid, 0);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        check_eq("refill_hold_req", mem_req, 1);
        check_eq("refill_hold_addr", mem_addr, addr);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("update_rpl_wr", rpl_wr, exp_ctr);
      check_eq("update_rpl_addr", rpl_addr, set);
      check_eq("update_rpl_hit", rpl_hit, 0);
      check_eq("update_mem_req", mem_req, 0);
      check_eq("update_resp_valid", resp_valid, 0);
      @(negedge clk);
    end
    check_eq("resp_valid", resp_valid, 1);
    check_eq("resp_hit", resp_hit, exp_hit);
    check_eq("resp_way", resp_way, exp_way);
    check_eq("resp_ready_low", cpu_ready, 0);
    check_eq("resp_mem_req", mem_req, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      if (stray && i == 0) mem_ack = 1'b1;
      if (stray && i == 1) begin
        cpu_valid = 1'b1;
        cpu_addr  = addr ^ 14'h2A5;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_hit", resp_hit, exp_hit);
      check_eq("bp_way", resp_way, exp_way);
      check_eq("bp_cpu_ready", cpu_ready, 0);
      check_eq("bp_mem_req", mem_req, 0);
    end
    cpu_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("done_resp_valid", resp_valid, 0);
    check_eq("done_cpu_ready", cpu_ready, 1);
    check_eq("rpl_wr_count", rpl_wr_cnt - cnt0, exp_ctr);
  endtask

  // The address must currently miss; the aborted refill must leave no trace.
  task automatic run_reset_refill(input logic [13:0] addr);
    int cnt0;
    cnt0 = rpl_wr_cnt;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_refill_req", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_cpu_ready", cpu_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_rpl_wr_count", rpl_wr_cnt - cnt0, 0);
    clear_model();
  endtask

  task automatic stray_idle_ack();
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("stray_idle_ready", cpu_ready, 1);
    check_eq("stray_idle_req", mem_req, 0);
    check_eq("stray_idle_resp", resp_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    cpu_valid  = 1'b0;
    cpu_addr   = '0;
    resp_ready = 1'b0;
    mem_ack    = 1'b0;
    clear_model();
    for (int s = 0; s < 64; s++) m_ctr[s] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_cpu_ready", cpu_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_hit", resp_hit, 0);
    check_eq("rst_resp_way", resp_way, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_rpl_wr", rpl_wr, 0);
    check_eq("rst_rpl_hit", rpl_hit, 0);

    // Cold miss then hit on tag 0x03, set 5.
    run_req(14'h0C5, 3, 0, 1'b0);
    run_req(14'h0C5, 0, 0, 1'b0);
    // Fill the rest of set 5, then force a counter-driven replacement.
    for (int t = 4; t <= 10; t++) run_req({8'(t), 6'd5}, t % 3, 0, 1'b0);
    run_req({8'h0B, 6'd5}, 1, 0, 1'b0);
    run_req(14'h0C5, 0, 0, 1'b0);
    // Backpressure with stray ack and a blocked request in RESP.
    run_req({8'h05, 6'd5}, 0, 5, 1'b1);
    stray_idle_ack();
    run_req({8'h05, 6'd5}, 2, 0, 1'b0);
    // Abort in REFILL, then every prior line must miss.
    run_reset_refill({8'hFF, 6'd9});
    run_req(14'h0C5, 0, 0, 1'b0);
    run_req({8'h0B, 6'd5}, 1, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [13:0] a;
      int rd;
      a  = {8'($urandom_range(0, 11)), 6'($urandom_range(0, 3))};
      rd = $urandom_range(0, 3);
      run_req(a, $urandom_range(0, 3), rd, (rd >= 2) && ($urandom_range(0, 1) == 1));
      if (n % 50 == 25) stray_idle_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
